// File: rtl/id_stage_fwd.sv
// Instruction-decode stage: register file with write-through, opcode decode,
// load-use / branch-operand hazard detection, branch and jump resolution in ID
// with EX/MEM forwarding into the comparator, and the registered ID/EX bundle.
module id_stage_fwd #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_instr,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic [4:0]       id_ex_dest,
    input  logic             ex_mem_reg_write,
    input  logic             ex_mem_mem_read,
    input  logic [4:0]       ex_mem_dest,
    input  logic [XLEN-1:0]  ex_mem_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_reg,
    input  logic [XLEN-1:0]  wb_data,
    output logic             stall,
    output logic             flush,
    output logic             pc_src,
    output logic [XLEN-1:0]  pc_target,
    output logic             ex_valid,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic             ex_mem_write,
    output logic             ex_mem_read,
    output logic             ex_reg_dst,
    output logic             ex_alu_src,
    output logic [1:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_rs_data,
    output logic [XLEN-1:0]  ex_rt_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [5:0]       ex_funct,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int         IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] NREG_L = 6'(NREG);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    // Index refers to a real, writable register (r0 and out-of-range excluded).
    function automatic logic reg_live(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < NREG_L);
    endfunction

    // Producer with nonzero destination feeds rs, or rt when rt is a source.
    function automatic logic dep(input logic [4:0] dest, input logic [4:0] rs_i,
                                 input logic [4:0] rt_i, input logic use_rt);
        return (dest != 5'd0) && ((dest == rs_i) || (use_rt && (dest == rt_i)));
    endfunction

    // Saturating increment: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [XLEN-1:0] rf [NREG];

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    assign opcode = if_instr[31:26];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign rd     = if_instr[15:11];
    assign imm    = if_instr[15:0];

    logic [1:0] alu_op_p0;
    logic reg_dst_p0, alu_src_p0, mem_to_reg_p0, reg_write_p0, mem_read_p0, mem_write_p0;
    logic uses_rt_p0, is_beq_p0, is_bne_p0, is_jump_p0, is_branch_p0;
    logic wb_en, stall_p0, taken_p0, vld_p0;
    logic [XLEN-1:0] rs_val_p0, rt_val_p0, cmp_rs_p0, cmp_rt_p0;
    logic signed [XLEN-1:0] imm_sext_p0;

    // Opcode decode into control bits and operand usage.
    always_comb begin
        alu_op_p0     = 2'b00;
        reg_dst_p0    = 1'b0;
        alu_src_p0    = 1'b0;
        mem_to_reg_p0 = 1'b0;
        reg_write_p0  = 1'b0;
        mem_read_p0   = 1'b0;
        mem_write_p0  = 1'b0;
        uses_rt_p0    = 1'b0;
        is_beq_p0     = 1'b0;
        is_bne_p0     = 1'b0;
        is_jump_p0    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                alu_op_p0    = 2'b10;
                reg_dst_p0   = 1'b1;
                reg_write_p0 = 1'b1;
                uses_rt_p0   = 1'b1;
            end
            OP_LW: begin
                alu_src_p0    = 1'b1;
                mem_to_reg_p0 = 1'b1;
                reg_write_p0  = 1'b1;
                mem_read_p0   = 1'b1;
            end
            OP_SW: begin
                alu_src_p0   = 1'b1;
                mem_write_p0 = 1'b1;
                uses_rt_p0   = 1'b1;
            end
            OP_ADDI: begin
                alu_src_p0   = 1'b1;
                reg_write_p0 = 1'b1;
            end
            OP_BEQ: begin
                alu_op_p0  = 2'b01;
                uses_rt_p0 = 1'b1;
                is_beq_p0  = 1'b1;
            end
            OP_BNE: begin
                alu_op_p0  = 2'b01;
                uses_rt_p0 = 1'b1;
                is_bne_p0  = 1'b1;
            end
            OP_J:    is_jump_p0 = 1'b1;
            default: ;
        endcase
    end

    assign is_branch_p0 = is_beq_p0 | is_bne_p0;
    assign imm_sext_p0  = {{(XLEN-16){imm[15]}}, imm};
    assign wb_en        = wb_reg_write && reg_live(wb_reg);

    // Register-file reads with same-cycle write-through from WB.
    always_comb begin
        rs_val_p0 = '0;
        rt_val_p0 = '0;
        if (reg_live(rs))
            rs_val_p0 = (wb_en && wb_reg == rs) ? wb_data : rf[rs[IDX_W-1:0]];
        if (reg_live(rt))
            rt_val_p0 = (wb_en && wb_reg == rt) ? wb_data : rf[rt[IDX_W-1:0]];
    end

    // Hazards, comparator forwarding from MEM, and branch/jump resolution.
    always_comb begin
        stall_p0 = if_valid && (
            (id_ex_mem_read && dep(id_ex_dest, rs, rt, uses_rt_p0)) ||
            (is_branch_p0 && id_ex_reg_write && dep(id_ex_dest, rs, rt, uses_rt_p0)) ||
            (is_branch_p0 && ex_mem_mem_read && dep(ex_mem_dest, rs, rt, uses_rt_p0)));

        cmp_rs_p0 = rs_val_p0;
        cmp_rt_p0 = rt_val_p0;
        if (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_dest != 5'd0) begin
            if (ex_mem_dest == rs) cmp_rs_p0 = ex_mem_result;
            if (ex_mem_dest == rt) cmp_rt_p0 = ex_mem_result;
        end

        taken_p0 = (is_beq_p0 && (cmp_rs_p0 == cmp_rt_p0)) ||
                   (is_bne_p0 && (cmp_rs_p0 != cmp_rt_p0)) || is_jump_p0;

        pc_target = '0;
        if (is_branch_p0)
            pc_target = if_pc + XLEN'(imm_sext_p0 <<< 2);
        else if (is_jump_p0)
            pc_target = {if_pc[XLEN-1:28], if_instr[25:0], 2'b00};
    end

    assign vld_p0 = if_valid && !stall_p0;
    assign stall  = stall_p0;
    assign pc_src = taken_p0 && vld_p0;
    assign flush  = pc_src;

    // Register file storage; reset wins over a simultaneous write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[wb_reg[IDX_W-1:0]] <= wb_data;
        end
    end

    // ---- ID -> EX boundary: bubbles clear valid and controls, data loads as-is ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_funct      <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
        end else begin
            ex_valid      <= vld_p0;
            ex_mem_to_reg <= vld_p0 & mem_to_reg_p0;
            ex_reg_write  <= vld_p0 & reg_write_p0;
            ex_mem_write  <= vld_p0 & mem_write_p0;
            ex_mem_read   <= vld_p0 & mem_read_p0;
            ex_reg_dst    <= vld_p0 & reg_dst_p0;
            ex_alu_src    <= vld_p0 & alu_src_p0;
            ex_alu_op     <= vld_p0 ? alu_op_p0 : 2'b00;
            ex_rs_data    <= rs_val_p0;
            ex_rt_data    <= rt_val_p0;
            ex_imm        <= imm_sext_p0;
            ex_funct      <= if_instr[5:0];
            ex_rs         <= rs;
            ex_rt         <= rt;
            ex_rd         <= rd;
        end
    end

    // Stall cycle counter, saturating.
    always_ff @(posedge clk) begin
        if (rst)           stall_cnt <= '0;
        else if (stall_p0) stall_cnt <= sat_inc(stall_cnt);
    end
endmodule

// File: doc/id_stage_fwd.md
# id_stage_fwd

Parametrised instruction-decode stage for the five-stage pipeline. It sits between the IF/ID register and EX and contains:
- the architectural register file, with write-through bypass;
- opcode decode;
- load-use and branch-operand hazard detection;
- branch and jump resolution in ID, with EX/MEM forwarding into the comparator;
- the registered ID/EX pipeline bundle, with a valid bit and bubble insertion.

It generalises the existing decode stage in data width, register count and branch types (adds `bne`), and adds a saturating stall counter.

## Interface
Parameters:
- `XLEN`, 32: data and PC width; must be at least 32.
- `NREG`, 32: number of architectural registers; a power of two, at most 32.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk`  in  1  the single clock; every flop updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `if_valid`  in  1  IF/ID holds a real instruction.
- `if_pc`  in  XLEN  PC+4 of the instruction in ID.
- `if_instr`  in  32  MIPS-encoded instruction.
- `id_ex_mem_read`, `id_ex_reg_write`  in  1  control bits of the instruction currently in EX.
- `id_ex_dest`  in  5  destination register of the instruction in EX.
- `ex_mem_reg_write`, `ex_mem_mem_read`  in  1  control bits of the instruction in MEM.
- `ex_mem_dest`  in  5  destination register of the instruction in MEM.
- `ex_mem_result`  in  XLEN  ALU result of the instruction in MEM.
- `wb_reg_write`  in  1  write-back enable.
- `wb_reg`  in  5  write-back register index.
- `wb_data`  in  XLEN  write-back data.
- `stall`  out  1  hold PC and IF/ID this cycle; combinational.
- `flush`  out  1  squash IF/ID; combinational.
- `pc_src`  out  1  select `pc_target`; combinational.
- `pc_target`  out  XLEN  branch or jump target.
- `ex_valid`, `ex_mem_to_reg`, `ex_reg_write`, `ex_mem_write`, `ex_mem_read`, `ex_reg_dst`, `ex_alu_src`  out  1  registered ID/EX control bits.
- `ex_alu_op`  out  2  registered ALU operation class.
- `ex_rs_data`, `ex_rt_data`, `ex_imm`  out  XLEN  registered operands and sign-extended immediate.
- `ex_funct`  out  6  registered function field.
- `ex_rs`, `ex_rt`, `ex_rd`  out  5  registered register indices.
- `stall_cnt`  out  CNT_W  count of stall cycles.

## Operation
- **Decode table** (`alu_op`/`reg_dst`/`alu_src`/`mem_to_reg`/`reg_write`/`mem_read`/`mem_write`):
  - R-type 0x00: 10/1/0/0/1/0/0.
  - `lw` 0x23: 00/0/1/1/1/1/0.
  - `sw` 0x2B: 00/x/1/x/0/0/1.
  - `addi` 0x08: 00/0/1/0/1/0/0.
  - `beq` 0x04, `bne` 0x05: 01, no writes.
  - `j` 0x02: all control bits 0.
  - Any other opcode: all control bits 0, `ex_valid`=1.
- **`uses_rt`**: true for R-type, `sw`, `beq` and `bne`.
- **Register file** (`NREG`×`XLEN`):
  - Register 0 always reads as 0; writes to it are ignored.
  - A write occurs at the clock edge when `wb_reg_write` is high and `wb_reg` is nonzero and below `NREG`.
  - Reads are combinational, with write-through: a same-cycle write to the register being read returns `wb_data`.
  - Indices at or above `NREG` read as 0.
- **Hazards** (all require `if_valid`, and a nonzero destination that matches rs, or matches rt with `uses_rt`):
  - Load-use: `id_ex_mem_read` is set.
  - Branch on EX result: a branch is in ID and `id_ex_reg_write` is set.
  - Branch on MEM load: a branch is in ID and `ex_mem_mem_read` is set.
  - `stall` is the OR of these three.
- **Comparator forwarding**, per operand:
  - Use `ex_mem_result` if `ex_mem_reg_write` is set, `ex_mem_mem_read` is clear, and `ex_mem_dest` is nonzero and matches the operand.
  - Otherwise use the register-file read.
- **Branch and jump resolution**:
  - Taken when `beq` and the operands are equal, `bne` and the operands differ, or `j`.
  - `pc_src` = `flush` = taken AND `if_valid` AND NOT `stall`.
  - Branch target: `pc_target` = `if_pc` + (`sext(imm)` << 2), computed modulo 2^XLEN.
  - Jump target: `pc_target` = {`if_pc[XLEN-1:28]`, `instr[25:0]`, 2'b00}.
  - Otherwise `pc_target` = 0.
- **ID/EX register**:
  - A bubble is loaded when `stall` is high or `if_valid` is low. A bubble clears `ex_valid` and all control bits; the data fields load normally.
  - Otherwise the decoded instruction is loaded with `ex_valid`=1.
  - `ex_rs_data` and `ex_rt_data` take the register-file values, not the comparator-forwarded values; EX forwards separately.
- **`stall_cnt`**: increments on each cycle where `stall` is high and holds at all-ones.

## Timing
- **Reset**: `rst` high at an edge clears every ID/EX output, `stall_cnt` and all registers in the register file. Reset takes priority over a simultaneous write-back.
- **Outputs during reset**: `stall`, `flush` and `pc_src` are combinational. They may assert while `rst` is held, and IF ignores them during reset.
- **Latency**:
  - Hazard and branch outputs are valid in the same cycle as the instruction in ID.
  - ID/EX outputs update one edge later.
- **Stall length**: load-use and branch-on-EX stalls last one cycle each. Branch-on-MEM-load stalls for one cycle after the load reaches MEM, so a branch that depends on a load stalls twice in total.
- **Stall precedence**: while `stall` is high, `pc_src` stays low even if the comparison would be taken.
- **Taken branch or jump**: the branch itself enters ID/EX with `ex_valid`=1 and no write controls. IF/ID is flushed on the same edge.
- **Simultaneous write-back and read**: the new value is visible in both the comparator and `ex_*_data` in that same cycle.

## Test plan
1. **Write-through and register 0**: write 0x1234 to r5 via WB while ID reads rs=5, then write r0=7 and read r0 → `ex_rs_data`=0x1234 on the next edge; r0 reads 0.
2. **Load-use stall**: `lw` r2 in EX with an `add` r3=r2+r4 in ID → `stall`=1 for exactly one cycle; the bubble gives `ex_valid`=0 and `ex_reg_write`=0; `stall_cnt` goes 0→1.
3. **`beq` forwarded from MEM**: ALU result 5 for r1 in MEM, r2=5 in the register file, `beq` r1,r2,+3 with `if_pc`=0x100 → `pc_src`=`flush`=1, `pc_target`=0x10C.
4. **`bne` behind an ALU producer**: `addi` r1 in EX feeding `bne` r1,r0 in ID → one stall cycle, then the branch resolves through MEM forwarding. `pc_target` is 0xFC with offset -1 and `if_pc`=0x100.
5. **Jump**: `j` 0x0000040 with `if_pc`=0x4000_0010 → `pc_target`=0x4000_0100, `pc_src`=1, and ID/EX receives `ex_valid`=1 with all controls 0.
6. **Reset mid-stream and counter saturation**:
   - Assert `rst` during a stall → all outputs 0 on the next edge.
   - With `CNT_W`=2, force stalls for 5 cycles → `stall_cnt` holds at 3.
